// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by the 8O1 receiver and its matching transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT = 868;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8O1 UART receiver: start validation, mid-bit sampling, parity/stop checks.
// Ports: clk, rst, rx_in -> data, valid, parity_err, frame_err, busy.
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_rx_state_t state, state_n;

  logic                 line;
  logic                 line_d;
  logic                 fall;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 done;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (line)
  );

  always_ff @(posedge clk) begin
    if (rst) line_d <= 1'b1;
    else     line_d <= line;
  end

  // Edge-triggered start: a line stuck low never re-arms IDLE.
  assign fall = line_d & ~line;
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {line, shreg[DATA_BITS-1:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = PARITY;
        end
      end
      PARITY: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          par_n   = line;
          state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is seen.
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      par     <= par_n;
      valid   <= done;
      if (done) begin
        data       <= shreg;
        parity_err <= ~^{shreg, par};
        frame_err  <= ~line;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level model.
// Drives 8O1 frames at nominal and +/-2% rates; checks data, flags, latency.
module tb_uart_rx;

  localparam int C = 128;
  localparam int H = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLKS_PER_BIT (C),
    .HALF_BIT     (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("data", data, e.d);
        check("parity_err", parity_err, e.pe);
        check("frame_err", frame_err, e.fe);
        check("latency", cyc, e.at);
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic drive(input logic [7:0] b, input logic p,
                       input logic s, input int scale,
                       input int nbits);
    logic [10:0] f;
    int t0, t1;
    exp_t e;
    f = {s, p, b, 1'b0};
    if (nbits == 11) begin
      e.d  = b;
      e.pe = ((($countones(b) + int'(p)) % 2) == 0);
      e.fe = !s;
      e.at = cyc + 3 + H + 10 * C;
      exp_q.push_back(e);
    end
    for (int k = 0; k < nbits; k++) begin
      rx_in = f[k];
      t0 = (k * C * scale) / 1000;
      t1 = ((k + 1) * C * scale) / 1000;
      repeat (t1 - t0) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * 11 * C) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, data, 8'h00);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_pe"}, parity_err, 0);
    check({tag, "_fe"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int sc[3];
    logic [7:0] b;
    logic p;
    sc[0] = 1000;
    sc[1] = 980;
    sc[2] = 1020;

    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    idle(20);

    drive(8'hA5, 1'b1, 1'b1, 1000, 11);
    drive(8'h07, 1'b1, 1'b1, 1000, 11);
    idle(C);
    check("pe_hold", parity_err, 1);
    drive(8'h07, 1'b0, 1'b1, 1000, 11);
    idle(C);
    wait_drain();

    drive(8'h3C, 1'b1, 1'b0, 1000, 11);
    repeat (20 * C) @(posedge clk);
    #1;
    wait_drain();
    check("fe_hold", frame_err, 1);
    idle(2 * C);

    drive(8'h96, 1'b1, 1'b1, 1000, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    rst = 1'b0;
    idle(12 * C);
    check("midrst_idle", busy, 0);

    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_busy", busy, 1);
    rx_in = 1'b1;
    repeat (H + 10) @(posedge clk);
    #1;
    check("glitch_idle", busy, 0);
    idle(C);

    drive(8'h55, 1'b1, 1'b1, 1000, 11);
    idle(C);

    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 1'b1, 1'b1, sc[i], 11);
      drive(8'hFF, 1'b1, 1'b1, sc[i], 11);
      drive(8'h81, 1'b1, 1'b1, sc[i], 11);
      idle(2 * C);
    end
    wait_drain();

    drive(8'h5A, 1'b1, 1'b1, 1000, 11);
    idle(C);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      p = 1'($urandom % 2);
      drive(b, p, 1'b1, sc[$urandom_range(0, 2)], 11);
    end
    idle(C);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the 100 MHz fabric: 115200 bps nominal, 8O1 framing (start, 8 data bits LSB first, odd parity, 1 stop), the counterpart of the team's 8O1 transmitter. It synchronises the asynchronous line, validates the start bit, samples each bit at mid-period, and presents each received byte with a one-cycle `valid` strobe plus per-byte parity and framing error flags. It sits between the board RX pin and user logic, for example a command decoder or a loopback test against the transmitter.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 868 ≈ 115207 bps); must be ≥ 16.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (434): cycles from start-edge detection to the start-bit sample.
- `clk`, in, 1: clock, 100 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_in`, in, 1: asynchronous UART line; idles high.
- `data`, out, 8: last received byte; updated only with `valid`; held otherwise.
- `valid`, out, 1: one-cycle strobe; `data`, `parity_err` and `frame_err` are valid in this cycle.
- `parity_err`, out, 1: high when the parity of the 8 data bits plus the parity bit is even (odd parity violated).
- `frame_err`, out, 1: high when the stop bit was sampled 0.
- `busy`, out, 1: high from the start-edge detection until the stop-bit sample.

## Operation
- Input path: 2-FF synchroniser on `rx_in`, plus a third register for edge detection. Reset value of all three registers is 1 (line idle).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: the bit counter and the shift register hold. A synchronised 1→0 transition moves the FSM to START and clears the cycle counter.
- START: sample when the cycle counter reaches `HALF_BIT-1`.
  - Sample = 1: false start (glitch). Return to IDLE with no strobe.
  - Sample = 0: go to DATA and clear the cycle counter.
- DATA: sample each time the cycle counter reaches `CLKS_PER_BIT-1`; the counter wraps to 0 on that cycle. Shift right into an 8-bit register (first bit received ends in bit 0). Go to PARITY after the 8th sample.
- PARITY: take one sample at `CLKS_PER_BIT-1` and store it. Go to STOP.
- STOP: take one sample at `CLKS_PER_BIT-1`. In the next cycle:
  - `valid`=1;
  - `data` = shift register;
  - `parity_err` = ~^{data, parity};
  - `frame_err` = ~stop_sample.
  - The FSM returns to IDLE in that same cycle. This mid-stop return is required so that a back-to-back start edge is not missed.
- After a framing error (including a break), IDLE re-arms only on a fresh 1→0 edge. A line held low produces no further frames.
- `parity_err` and `frame_err` are updated only with `valid` and hold between strobes.
- `rst` in any state: FSM goes to IDLE and counters go to 0. No `valid` is generated for the aborted frame.

## Timing
- Reset values: `data`=0x00, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- Line falling edge to IDLE→START: 3 clocks (2 synchroniser stages + edge register).
- Edge-detect cycle to start sample: `HALF_BIT` clocks.
- `valid` is asserted `HALF_BIT` + 10·`CLKS_PER_BIT` + 1 = 9115 clocks after the edge-detect cycle.
- `busy` rises in the cycle after edge detection and falls in the `valid` cycle.
- Cycle counter: `$clog2(CLKS_PER_BIT)` bits, unsigned, never exceeds `CLKS_PER_BIT-1`.
- Required tolerance: a transmitter bit rate within ±2 % of nominal is received error-free.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT` (868) and `HALF_BIT` constants, which the transmitter also uses;
  - state enum `uart_rx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - `DATA_BITS` (8).
- One sub-module, `sync_2ff`: 1-bit, reset value parameterised (1 here), reusable for other asynchronous inputs.
- Everything else lives in `uart_rx`: FSM, cycle counter, bit counter (3 bits), shift register, output registers.

## Test plan
- Send 0xA5 with parity bit 1 and stop bit 1 at nominal rate → exactly one `valid`; `data`=0xA5, `parity_err`=0, `frame_err`=0; `valid` exactly 9115 clocks after edge detection.
- Send 0x07 with parity bit 1 (wrong) → `valid`, `data`=0x07, `parity_err`=1, `frame_err`=0. Then send 0x07 with parity 0 → `parity_err`=0.
- Send 0x3C with stop bit 0 and hold the line low for 20 bit times → one `valid` with `frame_err`=1; no further `valid` until the line returns high and a new frame is sent.
- Low glitch of 200 clocks on an idle line → no `valid`, `busy` returns to 0, FSM in IDLE; a following 0x55 frame is received correctly.
- Back-to-back frames 0x00, 0xFF, 0x81 from the team's transmitter in loopback, plus the same frames at ±2 % bit rate → three `valid` strobes, correct data, no error flags.
- Assert `rst` for 1 clock mid-DATA of a frame → outputs return to reset values, no `valid` for the aborted frame; the next full frame 0x5A is received correctly.
